port_uart_bridge: RTL and testbench



---
 rtl/port_uart_bridge_if.sv | 25 ++
 rtl/port_uart_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_port_uart_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/port_uart_bridge_if.sv
// Port-pair bundle between the core's memory-mapped port registers and the UART bridge.
`timescale 1ns/1ps

interface port_uart_bridge_if;
    logic [31:0] portOutputWord;
    logic [31:0] portInputWord;
    logic        txd;
    logic        rxd;

    // Core / link-partner side.
    modport master (
        output portOutputWord,
        output rxd,
        input  portInputWord,
        input  txd
    );

    // Bridge side.
    modport slave (
        input  portOutputWord,
        input  rxd,
        output portInputWord,
        output txd
    );
endinterface

// File: rtl/port_uart_bridge.sv
// Port-register to 8N1 UART bridge. The port words carry no strobes, so
// transfers in each direction are signalled by toggle handshakes.
`timescale 1ns/1ps

module port_uart_bridge #(
    parameter int unsigned CLOCKS_PER_BIT = 434
) (
    input  logic              clock,
    input  logic              reset,
    port_uart_bridge_if.slave bus
);

    localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLOCKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // Port word fields
    logic [7:0] tx_data_in;
    logic       tx_req_toggle;
    logic       rx_ack_toggle;
    logic       unused_port_bits;

    assign tx_data_in       = bus.portOutputWord[7:0];
    assign tx_req_toggle    = bus.portOutputWord[8];
    assign rx_ack_toggle    = bus.portOutputWord[9];
    assign unused_port_bits = ^bus.portOutputWord[31:10];

    // TX state
    uart_state_e       tx_state_q, tx_state_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              txd_q, txd_d;
    logic              tx_req_seen_q, tx_req_seen_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_busy_q, tx_busy_d;

    // RX state
    logic              rx_sync1_q, rx_sync1_d;
    logic              rx_sync2_q, rx_sync2_d;
    logic              rx_prev_q, rx_prev_d;
    uart_state_e       rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              rx_ferr_q, rx_ferr_d;
    logic              ack_seen_q, ack_seen_d;

    logic              rx_pending;

    assign rx_pending = rx_valid_q != rx_ack_toggle;

    // Transmit FSM: idle -> start bit -> 8 data bits LSB first -> stop bit
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_baud_d     = tx_baud_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        txd_d         = txd_q;
        tx_req_seen_d = tx_req_seen_q;
        tx_done_d     = tx_done_q;
        tx_busy_d     = tx_busy_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_baud_d = '0;
                if (tx_req_toggle != tx_req_seen_q) begin
                    tx_shift_d    = tx_data_in;
                    tx_req_seen_d = tx_req_toggle;
                    tx_busy_d     = 1'b1;
                    txd_d         = 1'b0;
                    tx_state_d    = S_START;
                end
            end
            S_START: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = S_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_done_d  = tx_req_seen_q;
                    tx_busy_d  = 1'b0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
        endcase
    end

    // Receive FSM plus ack handling; an error set in the same cycle as an ack wins
    always_comb begin
        rx_sync1_d   = bus.rxd;
        rx_sync2_d   = rx_sync1_q;
        rx_prev_d    = rx_sync2_q;
        rx_state_d   = rx_state_q;
        rx_baud_d    = rx_baud_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        rx_ferr_d    = rx_ferr_q;
        ack_seen_d   = ack_seen_q;

        if (rx_ack_toggle != ack_seen_q) begin
            rx_overrun_d = 1'b0;
            rx_ferr_d    = 1'b0;
            ack_seen_d   = rx_ack_toggle;
        end

        case (rx_state_q)
            S_IDLE: begin
                rx_baud_d = '0;
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_state_d = S_IDLE;
                    if (!rx_sync2_q) begin
                        rx_ferr_d = 1'b1;
                    end else if (rx_pending) begin
                        rx_overrun_d = 1'b1;
                    end else begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = ~rx_valid_q;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_q    <= S_IDLE;
            tx_baud_q     <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            txd_q         <= 1'b1;
            tx_req_seen_q <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_busy_q     <= 1'b0;
            rx_sync1_q    <= 1'b1;
            rx_sync2_q    <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_baud_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            rx_ferr_q     <= 1'b0;
            ack_seen_q    <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_baud_q     <= tx_baud_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            txd_q         <= txd_d;
            tx_req_seen_q <= tx_req_seen_d;
            tx_done_q     <= tx_done_d;
            tx_busy_q     <= tx_busy_d;
            rx_sync1_q    <= rx_sync1_d;
            rx_sync2_q    <= rx_sync2_d;
            rx_prev_q     <= rx_prev_d;
            rx_state_q    <= rx_state_d;
            rx_baud_q     <= rx_baud_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            rx_ferr_q     <= rx_ferr_d;
            ack_seen_q    <= ack_seen_d;
        end
    end

    assign bus.txd           = txd_q;
    assign bus.portInputWord = {19'b0, rx_ferr_q, rx_overrun_q, tx_busy_q,
                                rx_valid_q, tx_done_q, rx_data_q};

endmodule

// File: tb/tb_port_uart_bridge.sv
// Directed bench for port_uart_bridge at 4 clocks per bit.
`timescale 1ns/1ps

module tb_port_uart_bridge;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    port_uart_bridge_if u_if();

    port_uart_bridge #(.CLOCKS_PER_BIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one 8N1 frame on rxd (4 clocks per bit) followed by idle time.
    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        u_if.rxd = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            u_if.rxd = d[i];
            repeat (4) tick();
        end
        u_if.rxd = stop_bit;
        repeat (4) tick();
        u_if.rxd = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        u_if.portOutputWord = 32'h0;
        u_if.rxd = 1'b1;
        repeat (3) tick();
        checks++;
        if (u_if.txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd: got %b expected 1", u_if.txd);
        end
        checks++;
        if (u_if.portInputWord !== 32'h0) begin
            errors++;
            $display("FAIL reset_piw: got %h expected 00000000", u_if.portInputWord);
        end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        u_if.portOutputWord = 32'h155;
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++;
            if (u_if.txd !== frame[c/4]) begin
                errors++;
                $display("FAIL tx_bit cycle %0d: got %b expected %b", c, u_if.txd, frame[c/4]);
            end
            checks++;
            if (u_if.portInputWord[10] !== 1'b1) begin
                errors++;
                $display("FAIL tx_busy cycle %0d: got %b expected 1", c, u_if.portInputWord[10]);
            end
        end
        tick();
        checks++;
        if (u_if.portInputWord !== 32'h100) begin
            errors++;
            $display("FAIL tx_done_word: got %h expected 00000100", u_if.portInputWord);
        end
    endtask

    task automatic test_rx_basic();
        send_rx(8'hA3, 1'b1);
        checks++;
        if (u_if.portInputWord !== 32'h3A3) begin
            errors++;
            $display("FAIL rx_a3: got %h expected 000003a3", u_if.portInputWord);
        end
        u_if.portOutputWord = 32'h355;
        repeat (3) tick();
        checks++;
        if (u_if.portInputWord !== 32'h3A3) begin
            errors++;
            $display("FAIL rx_ack_a3: got %h expected 000003a3", u_if.portInputWord);
        end
    endtask

    task automatic test_rx_overrun();
        send_rx(8'h11, 1'b1);
        checks++;
        if (u_if.portInputWord !== 32'h111) begin
            errors++;
            $display("FAIL rx_11: got %h expected 00000111", u_if.portInputWord);
        end
        send_rx(8'h22, 1'b1);
        checks++;
        if (u_if.portInputWord !== 32'h911) begin
            errors++;
            $display("FAIL rx_overrun: got %h expected 00000911", u_if.portInputWord);
        end
        u_if.portOutputWord = 32'h155;
        repeat (2) tick();
        checks++;
        if (u_if.portInputWord !== 32'h111) begin
            errors++;
            $display("FAIL rx_overrun_clear: got %h expected 00000111", u_if.portInputWord);
        end
    endtask

    task automatic test_rx_framing_glitch();
        send_rx(8'h5A, 1'b0);
        checks++;
        if (u_if.portInputWord !== 32'h1111) begin
            errors++;
            $display("FAIL rx_framing: got %h expected 00001111", u_if.portInputWord);
        end
        u_if.rxd = 1'b0;
        tick();
        u_if.rxd = 1'b1;
        repeat (12) tick();
        checks++;
        if (u_if.portInputWord !== 32'h1111) begin
            errors++;
            $display("FAIL rx_glitch: got %h expected 00001111", u_if.portInputWord);
        end
        u_if.portOutputWord = 32'h355;
        repeat (2) tick();
        checks++;
        if (u_if.portInputWord !== 32'h111) begin
            errors++;
            $display("FAIL rx_framing_clear: got %h expected 00000111", u_if.portInputWord);
        end
        u_if.portOutputWord = 32'h155;
        repeat (2) tick();
        checks++;
        if (u_if.portInputWord !== 32'h111) begin
            errors++;
            $display("FAIL rx_ack_back: got %h expected 00000111", u_if.portInputWord);
        end
    endtask

    task automatic test_tx_double_toggle();
        u_if.portOutputWord = 32'h0AA;
        tick();
        checks++;
        if (u_if.portInputWord[10] !== 1'b1) begin
            errors++;
            $display("FAIL dbl_busy_start: got %b expected 1", u_if.portInputWord[10]);
        end
        repeat (9) tick();
        u_if.portOutputWord = 32'h1AA;
        repeat (2) tick();
        u_if.portOutputWord = 32'h0AA;
        repeat (29) tick();
        checks++;
        if (u_if.portInputWord !== 32'h011) begin
            errors++;
            $display("FAIL dbl_end_word: got %h expected 00000011", u_if.portInputWord);
        end
        repeat (5) tick();
        checks++;
        if (u_if.portInputWord[10] !== 1'b0 || u_if.txd !== 1'b1) begin
            errors++;
            $display("FAIL dbl_no_extra: busy %b txd %b expected busy 0 txd 1",
                     u_if.portInputWord[10], u_if.txd);
        end
    endtask

    task automatic test_back_to_back();
        u_if.portOutputWord = 32'h10F;
        tick();
        repeat (4) tick();
        checks++;
        if (u_if.txd !== 1'b1) begin
            errors++;
            $display("FAIL b2b_f1_bit0: got %b expected 1", u_if.txd);
        end
        repeat (5) tick();
        u_if.portOutputWord = 32'h0F0;
        repeat (12) tick();
        checks++;
        if (u_if.txd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_f1_bit4: got %b expected 0", u_if.txd);
        end
        repeat (19) tick();
        checks++;
        if (u_if.portInputWord !== 32'h111) begin
            errors++;
            $display("FAIL b2b_f1_done: got %h expected 00000111", u_if.portInputWord);
        end
        tick();
        checks++;
        if (u_if.portInputWord[10] !== 1'b1 || u_if.txd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_f2_start: busy %b txd %b expected busy 1 txd 0",
                     u_if.portInputWord[10], u_if.txd);
        end
        repeat (4) tick();
        checks++;
        if (u_if.txd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_f2_bit0: got %b expected 0", u_if.txd);
        end
        repeat (16) tick();
        checks++;
        if (u_if.txd !== 1'b1) begin
            errors++;
            $display("FAIL b2b_f2_bit4: got %b expected 1", u_if.txd);
        end
        repeat (20) tick();
        checks++;
        if (u_if.portInputWord !== 32'h011) begin
            errors++;
            $display("FAIL b2b_f2_done: got %h expected 00000011", u_if.portInputWord);
        end
        repeat (4) tick();
        checks++;
        if (u_if.portInputWord[10] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_third: busy %b expected 0", u_if.portInputWord[10]);
        end
    endtask

    task automatic test_midframe_reset();
        u_if.portOutputWord = 32'h1C3;
        u_if.rxd = 1'b0;
        repeat (15) tick();
        reset = 1'b0;
        u_if.rxd = 1'b1;
        u_if.portOutputWord = 32'h0;
        tick();
        checks++;
        if (u_if.txd !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_txd: got %b expected 1", u_if.txd);
        end
        checks++;
        if (u_if.portInputWord !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_piw: got %h expected 00000000", u_if.portInputWord);
        end
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (u_if.txd !== 1'b1 || u_if.portInputWord !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_idle: txd %b piw %h expected 1 00000000",
                     u_if.txd, u_if.portInputWord);
        end
        send_rx(8'h3C, 1'b1);
        checks++;
        if (u_if.portInputWord !== 32'h23C) begin
            errors++;
            $display("FAIL post_reset_rx: got %h expected 0000023c", u_if.portInputWord);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_rx_basic();
        test_rx_overrun();
        test_rx_framing_glitch();
        test_tx_double_toggle();
        test_back_to_back();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
